// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared defaults, write-source encoding and priority select for reg_bank
package reg_bank_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 32;
  typedef enum logic [1:0] {SRC_NONE, SRC_LD, SRC_C, SRC_F} src_e;
  function automatic src_e pick_src(input logic ld, input logic c, input logic f);
    return ld ? SRC_LD : c ? SRC_C : f ? SRC_F : SRC_NONE;
  endfunction
endpackage

// File: rtl/reg_bank_if.sv
// reg_bank_if: register-bank bus (read ports A/B, three write sources, status, flattened array)
// master drives addresses/requests/clr_err; slave returns a_out/b_out/data/wb_busy/bus_err
interface reg_bank_if #(parameter int WIDTH = 8, parameter int DEPTH = 32);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] ra_sel, rb_sel, wr_sel;
  logic ld_en, c_en, f_en, clr_err;
  logic [WIDTH-1:0] ld_data, c_data, f_data, a_out, b_out;
  logic [WIDTH*DEPTH-1:0] data;
  logic wb_busy, bus_err;
  modport master (
    output ra_sel, rb_sel, wr_sel, ld_en, c_en, f_en, clr_err, ld_data, c_data, f_data,
    input a_out, b_out, data, wb_busy, bus_err
  );
  modport slave (
    input ra_sel, rb_sel, wr_sel, ld_en, c_en, f_en, clr_err, ld_data, c_data, f_data,
    output a_out, b_out, data, wb_busy, bus_err
  );
endinterface

// File: rtl/reg_word.sv
// reg_word: WIDTH-bit storage word with synchronous active-high reset and write enable
// ports: clk, rst, we_i (write strobe), d_i (write data), q_o (stored word)
module reg_word #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  always_ff @(posedge clk)
    if (rst) q_o <= '0;
    else if (we_i) q_o <= d_i;
endmodule

// File: rtl/reg_bank.sv
// reg_bank: WIDTH x DEPTH register bank, two async read ports, prioritised pipelined write port
// ports: clk, rst (sync, active-high), bus (reg_bank_if.slave: addresses, ld/c/f sources,
// clr_err in; a_out, b_out, data, wb_busy, bus_err out)
// REG_BANK_BYPASS_EN: when defined, read ports forward the pending write-back data
module reg_bank import reg_bank_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic       clk,
  input logic       rst,
  reg_bank_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  src_e src;
  logic multi;
  logic wb_valid_q, wb_valid_d, bus_err_q, bus_err_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic [WIDTH-1:0] mem [DEPTH];
  always_comb begin
    src = pick_src(bus.ld_en, bus.c_en, bus.f_en);
    multi = (bus.ld_en & bus.c_en) | (bus.ld_en & bus.f_en) | (bus.c_en & bus.f_en);
    wb_valid_d = src != SRC_NONE;
    wb_addr_d = wb_valid_d ? bus.wr_sel : wb_addr_q;
    wb_data_d = src == SRC_LD ? bus.ld_data : src == SRC_C ? bus.c_data :
                src == SRC_F ? bus.f_data : wb_data_q;
    // a new conflict outranks a simultaneous clear
    bus_err_d = multi | (bus_err_q & ~bus.clr_err);
  end
  always_ff @(posedge clk)
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      bus_err_q <= bus_err_d;
    end
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    reg_word #(.WIDTH(WIDTH)) u_word (
      .clk  (clk),
      .rst  (rst),
      .we_i (wb_valid_q && wb_addr_q == AW'(i)),
      .d_i  (wb_data_q),
      .q_o  (mem[i])
    );
    assign bus.data[WIDTH*i +: WIDTH] = mem[i];
  end
`ifdef REG_BANK_BYPASS_EN
  assign bus.a_out = (wb_valid_q && wb_addr_q == bus.ra_sel) ? wb_data_q : mem[bus.ra_sel];
  assign bus.b_out = (wb_valid_q && wb_addr_q == bus.rb_sel) ? wb_data_q : mem[bus.rb_sel];
`else
  assign bus.a_out = mem[bus.ra_sel];
  assign bus.b_out = mem[bus.rb_sel];
`endif
  assign bus.wb_busy = wb_valid_q;
  assign bus.bus_err = bus_err_q;
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: self-checking bench for reg_bank (hand sequences plus table-driven scoreboard)
module tb_reg_bank;
  localparam int W = 8;
  localparam int D = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  reg_bank_if #(.WIDTH(W), .DEPTH(D)) bus();
  reg_bank #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic ld, c, f, clr;
    logic [4:0] addr;
    logic [7:0] ld_d, c_d, f_d, exp;
  } vec_t;
  typedef struct {
    logic [4:0] addr;
    logic [7:0] val;
  } sb_t;
  vec_t vt [10];
  sb_t q [$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.ld_en = 0; bus.c_en = 0; bus.f_en = 0; bus.clr_err = 0;
  endtask
  task automatic wr(input logic ld, input logic c, input logic f, input logic [4:0] a,
                    input logic [7:0] ldd, input logic [7:0] cd, input logic [7:0] fd);
    bus.ld_en = ld; bus.c_en = c; bus.f_en = f; bus.wr_sel = a;
    bus.ld_data = ldd; bus.c_data = cd; bus.f_data = fd;
  endtask
  function automatic logic [7:0] rg(input logic [4:0] a);
    return bus.data[a*W +: W];
  endfunction
  initial begin
    logic err_m;
    sb_t e;
    idle();
    bus.ra_sel = 0; bus.rb_sel = 0; wr(0, 0, 0, 0, 0, 0, 0);
    step(); step();
    rst = 0;
    chk("init_data", {31'd0, bus.data == '0}, 1);
    chk("init_busy", bus.wb_busy, 0);
    chk("init_err", bus.bus_err, 0);
    // reset clears committed contents
    wr(1, 0, 0, 3, 8'hA5, 0, 0); step(); idle(); step();
    chk("pre_rst_r3", rg(3), 8'hA5);
    rst = 1; step(); rst = 0;
    bus.ra_sel = 3; #1;
    chk("rst_data", {31'd0, bus.data == '0}, 1);
    chk("rst_busy", bus.wb_busy, 0);
    chk("rst_err", bus.bus_err, 0);
    chk("rst_a_out", bus.a_out, 0);
    // write/commit latency
    wr(1, 0, 0, 5, 8'h3C, 0, 0); step(); idle();
    chk("lat_busy", bus.wb_busy, 1);
    chk("lat_r5_before", rg(5), 0);
    step();
    chk("lat_r5_after", bus.data[47:40], 8'h3C);
    chk("lat_busy_idle", bus.wb_busy, 0);
    // priority and sticky error
    wr(1, 1, 0, 7, 8'h11, 8'h22, 0); step(); idle();
    chk("prio_err_set", bus.bus_err, 1);
    step();
    chk("prio_r7", rg(7), 8'h11);
    chk("prio_err_held", bus.bus_err, 1);
    bus.clr_err = 1; step(); bus.clr_err = 0;
    chk("err_cleared", bus.bus_err, 0);
    wr(1, 0, 1, 8, 8'h44, 0, 8'h55); bus.clr_err = 1; step(); idle();
    chk("err_set_wins", bus.bus_err, 1);
    step();
    chk("prio_r8", rg(8), 8'h44);
    bus.clr_err = 1; step(); bus.clr_err = 0;
    // read-after-write bypass behaviour
    wr(0, 0, 1, 9, 0, 0, 8'h7E); step(); idle();
    bus.ra_sel = 9; bus.rb_sel = 9; #1;
`ifdef REG_BANK_BYPASS_EN
    chk("byp_a", bus.a_out, 8'h7E);
    chk("byp_b", bus.b_out, 8'h7E);
`else
    chk("byp_a", bus.a_out, 8'h00);
    chk("byp_b", bus.b_out, 8'h00);
`endif
    chk("byp_data_old", rg(9), 8'h00);
    step();
    chk("byp_a_commit", bus.a_out, 8'h7E);
    chk("byp_b_commit", bus.b_out, 8'h7E);
    // back-to-back writes, same address twice
    wr(1, 0, 0, 1, 8'h01, 0, 0); step();
    chk("b2b_busy0", bus.wb_busy, 1);
    wr(1, 0, 0, 1, 8'h02, 0, 0); step();
    chk("b2b_busy1", bus.wb_busy, 1);
    chk("b2b_r1_first", rg(1), 8'h01);
    wr(1, 0, 0, 2, 8'h03, 0, 0); step(); idle();
    chk("b2b_busy2", bus.wb_busy, 1);
    chk("b2b_r1_second", rg(1), 8'h02);
    step();
    chk("b2b_r1", rg(1), 8'h02);
    chk("b2b_r2", rg(2), 8'h03);
    // reset while a write is pending, with a request held during reset
    wr(1, 0, 0, 4, 8'hFF, 0, 0); step();
    rst = 1; step(); rst = 0; idle();
    chk("rmw_busy", bus.wb_busy, 0);
    step();
    chk("rmw_r4", rg(4), 0);
    chk("rmw_busy2", bus.wb_busy, 0);
    // table-driven stream with scoreboard
    vt[0] = '{1, 0, 0, 0, 10, 8'h41, 8'h42, 8'h43, 8'h41};
    vt[1] = '{0, 1, 0, 0, 11, 8'h51, 8'h52, 8'h53, 8'h52};
    vt[2] = '{0, 0, 1, 0, 12, 8'h61, 8'h62, 8'h63, 8'h63};
    vt[3] = '{0, 1, 1, 0, 13, 8'h71, 8'h72, 8'h73, 8'h72};
    vt[4] = '{0, 0, 0, 1, 14, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[5] = '{1, 1, 1, 0, 31, 8'h81, 8'h82, 8'h83, 8'h81};
    vt[6] = '{1, 0, 0, 1, 31, 8'h91, 8'h92, 8'h93, 8'h91};
    vt[7] = '{0, 0, 1, 0, 0, 8'hA1, 8'hA2, 8'hA3, 8'hA3};
    vt[8] = '{1, 0, 1, 1, 20, 8'hB1, 8'hB2, 8'hB3, 8'hB1};
    vt[9] = '{0, 0, 0, 0, 21, 8'hC1, 8'hC2, 8'hC3, 8'h00};
    err_m = 0;
    for (int i = 0; i < 10; i++) begin
      wr(vt[i].ld, vt[i].c, vt[i].f, vt[i].addr, vt[i].ld_d, vt[i].c_d, vt[i].f_d);
      bus.clr_err = vt[i].clr;
      step();
      err_m = (int'(vt[i].ld) + int'(vt[i].c) + int'(vt[i].f) >= 2) | (err_m & ~vt[i].clr);
      chk($sformatf("tbl%0d_busy", i), bus.wb_busy, vt[i].ld | vt[i].c | vt[i].f);
      chk($sformatf("tbl%0d_err", i), bus.bus_err, err_m);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("tbl%0d_commit_r%0d", i, e.addr), rg(e.addr), e.val);
      end
      if (vt[i].ld | vt[i].c | vt[i].f) q.push_back('{vt[i].addr, vt[i].exp});
    end
    idle(); step();
    while (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("tbl_final_r%0d", e.addr), rg(e.addr), e.val);
    end
    chk("tbl_r31", rg(31), 8'h91);
    chk("tbl_r14_untouched", rg(14), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
